// File: rtl/dl_router.sv
// dl_router: routes the HPS ioctl download stream into the Sky Skipper core.
// ROM bytes are decoded into one of four memory regions and pass through a
// small FIFO that drains to the memory write port under mem_busy backpressure.
// DIP bytes are latched directly. core_reset is held until the download has
// landed and RST_HOLD further cycles have elapsed.
// Optional feature macro: DL_CHECKSUM_EN (16-bit running sum of written bytes).
module dl_router #(
  parameter int unsigned RST_HOLD   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        mem_wr,
  output logic [1:0]  mem_region,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_data,
  input  logic        mem_busy,
  output logic [7:0]  dip_sw0,
  output logic [7:0]  dip_sw1,
  output logic [7:0]  dip_sw2,
  output logic        core_reset,
  output logic        dl_done,
  output logic        overflow,
  output logic [16:0] byte_count,
  output logic [15:0] checksum
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_HOLD} state_t;

  state_t        state;
  logic [7:0]    hold_cnt;

  logic [1:0]    fifo_region [FIFO_DEPTH];
  logic [14:0]   fifo_addr   [FIFO_DEPTH];
  logic [7:0]    fifo_data   [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic          rom_wr;
  logic          in_range;
  logic [1:0]    dec_region;
  logic [14:0]   dec_addr;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          dl_start;
  logic          clr;
  logic          dip_wr;

  // Region decode of the incoming ROM byte address.
  always_comb begin
    in_range   = 1'b1;
    dec_region = 2'd0;
    dec_addr   = ioctl_addr[14:0];
    if (ioctl_addr < 25'h0008000) begin
      dec_region = 2'd0;
      dec_addr   = ioctl_addr[14:0];
    end else if (ioctl_addr < 25'h000C000) begin
      dec_region = 2'd1;
      dec_addr   = {1'b0, ioctl_addr[13:0]};
    end else if (ioctl_addr < 25'h0010000) begin
      dec_region = 2'd2;
      dec_addr   = {1'b0, ioctl_addr[13:0]};
    end else if (ioctl_addr < 25'h0018000) begin
      dec_region = 2'd3;
      dec_addr   = ioctl_addr[14:0];
    end else begin
      in_range   = 1'b0;
    end
  end

  // Push/pop arbitration; a push into a full FIFO is accepted when a pop frees a slot.
  always_comb begin
    rom_wr    = ioctl_wr && ioctl_download && (ioctl_index == 8'd0);
    fifo_full = (count == FULL_CNT);
    pop       = (count != '0) && !mem_busy;
    push      = rom_wr && in_range && (!fifo_full || pop);
    drop      = rom_wr && in_range && fifo_full && !pop;
    dl_start  = ioctl_download && (ioctl_index == 8'd0);
    clr       = dl_start && ((state == S_IDLE) || (state == S_HOLD));
    dip_wr    = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0);
  end

  // FIFO storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_region[wr_ptr] <= dec_region;
      fifo_addr[wr_ptr]   <= dec_addr;
      fifo_data[wr_ptr]   <= ioctl_dout;
    end
  end

  // FIFO pointers/occupancy and the registered memory write port.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      mem_wr     <= 1'b0;
      mem_region <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      mem_wr <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        mem_region <= fifo_region[rd_ptr];
        mem_addr   <= fifo_addr[rd_ptr];
        mem_data   <= fifo_data[rd_ptr];
        rd_ptr     <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Accepted-byte counter (saturating) and sticky overflow, cleared on download start.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      byte_count <= '0;
      overflow   <= 1'b0;
    end else if (clr) begin
      byte_count <= push ? 17'd1 : 17'd0;
      overflow   <= drop;
    end else begin
      if (push && (byte_count != '1)) begin
        byte_count <= byte_count + 17'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Download sequencing with registered core_reset and dl_done.
  // HOLD lasts RST_HOLD cycles: the exit fires when the counter would step to zero.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
      dl_done    <= 1'b0;
    end else begin
      dl_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (dl_start) begin
            state      <= S_LOAD;
            core_reset <= 1'b1;
          end else begin
            core_reset <= 1'b0;
          end
        end
        S_LOAD: begin
          core_reset <= 1'b1;
          if (!ioctl_download) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          core_reset <= 1'b1;
          if ((count == '0) && !mem_wr) begin
            state    <= S_HOLD;
            hold_cnt <= 8'(RST_HOLD);
          end
        end
        S_HOLD: begin
          if (dl_start) begin
            state      <= S_LOAD;
            core_reset <= 1'b1;
          end else if (hold_cnt <= 8'd1) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            core_reset <= 1'b0;
            dl_done    <= 1'b1;
          end else begin
            hold_cnt   <= hold_cnt - 8'd1;
            core_reset <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

  // DIP byte latches; only bytes 0..2 exist.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dip_sw0 <= 8'h00;
      dip_sw1 <= 8'hC2;
      dip_sw2 <= 8'h00;
    end else if (dip_wr) begin
      unique case (ioctl_addr[2:0])
        3'd0:    dip_sw0 <= ioctl_dout;
        3'd1:    dip_sw1 <= ioctl_dout;
        3'd2:    dip_sw2 <= ioctl_dout;
        default: ;
      endcase
    end
  end

`ifdef DL_CHECKSUM_EN
  // Running sum of bytes as they are issued on the write port.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      checksum <= '0;
    end else if (clr) begin
      checksum <= pop ? {8'h00, fifo_data[rd_ptr]} : 16'h0000;
    end else if (pop) begin
      checksum <= checksum + {8'h00, fifo_data[rd_ptr]};
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
